// File: rtl/mp_add_pkg.sv
// Shared types and helpers for the serial multi-precision adder.
// Holds the beat width default, FSM states and index sizing.
package mp_add_pkg;

  localparam int BYTE_W_DEF = 8;
  localparam int NBYTES_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/byte_add_cin.sv
// One beat of the adder: W-bit add with carry-in.
// Purely combinational; the full W+1 result is kept.
module byte_add_cin #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] full;

  // Widen every operand so the top carry is never lost.
  always_comb begin
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    s    = full[W-1:0];
    cout = full[W];
  end

endmodule

// File: rtl/serial_mp_adder.sv
// Byte-serial multi-precision adder, LSB beat first.
// Carry chains beat to beat; one registered sum beat per accept.
module serial_mp_adder
  import mp_add_pkg::*;
#(
  parameter int BYTE_W = BYTE_W_DEF,
  parameter int NBYTES = NBYTES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] sum,
  output logic              out_last,
  output logic              carry_out,
  output logic              busy
);

  localparam int IW = idx_w(NBYTES);
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  state_t            state;
  logic [IW-1:0]     idx;
  logic              carry;
  logic [BYTE_W-1:0] s;
  logic              c_next;
  logic              take;
  logic              drain;
  logic              is_last;

  byte_add_cin #(
    .W(BYTE_W)
  ) u_add (
    .a   (a),
    .b   (b),
    .cin (carry),
    .s   (s),
    .cout(c_next)
  );

  // A beat may enter when the output slot is free or being emptied.
  always_comb begin
    in_ready = (!out_valid || out_ready) && !clr;
    take     = in_valid && in_ready;
    drain    = out_valid && out_ready;
    is_last  = (idx == LAST);
    busy     = (state == BUSY);
  end

  // Beat index, carry chain, FSM and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      out_last  <= 1'b0;
      carry_out <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      carry_out <= 1'b0;
    end else if (take) begin
      sum       <= s;
      out_valid <= 1'b1;
      if (is_last) begin
        state     <= IDLE;
        idx       <= '0;
        carry     <= 1'b0;
        out_last  <= 1'b1;
        carry_out <= c_next;
      end else begin
        state     <= BUSY;
        idx       <= idx + IW'(1);
        carry     <= c_next;
        out_last  <= 1'b0;
        carry_out <= 1'b0;
      end
    end else if (drain) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      carry_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_mp_adder.sv
// Bench for serial_mp_adder: directed and random operations
// checked against whole-operand arithmetic.
module tb_serial_mp_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] sum;
  logic       out_last;
  logic       carry_out;
  logic       busy;

  logic       n1_clr = 1'b0;
  logic       n1_in_valid = 1'b0;
  logic       n1_in_ready;
  logic [7:0] n1_a = '0;
  logic [7:0] n1_b = '0;
  logic       n1_out_valid;
  logic       n1_out_ready = 1'b1;
  logic [7:0] n1_sum;
  logic       n1_out_last;
  logic       n1_carry_out;
  logic       n1_busy;

  int total = 0;
  int bad = 0;

  logic       m_ov = 1'b0;
  logic [7:0] m_sum = '0;
  logic       m_last = 1'b0;
  logic       m_cout = 1'b0;
  int         m_idx = 0;
  logic       n1_seen_busy = 1'b0;

  always #5 clk = ~clk;

  serial_mp_adder #(.BYTE_W(8), .NBYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .out_last(out_last),
    .carry_out(carry_out), .busy(busy)
  );

  serial_mp_adder #(.BYTE_W(8), .NBYTES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(n1_clr),
    .in_valid(n1_in_valid), .in_ready(n1_in_ready),
    .a(n1_a), .b(n1_b),
    .out_valid(n1_out_valid), .out_ready(n1_out_ready),
    .sum(n1_sum), .out_last(n1_out_last),
    .carry_out(n1_carry_out), .busy(n1_busy)
  );

  always @(posedge clk) if (n1_busy === 1'b1) n1_seen_busy <= 1'b1;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic iv, input logic [7:0] ia,
                       input logic [7:0] ib, input logic ordy,
                       input logic [7:0] es, input logic el,
                       input logic ec, output logic acc);
    logic rdy;
    in_valid = iv;
    a = ia;
    b = ib;
    out_ready = ordy;
    #1;
    rdy = !m_ov || ordy;
    chk("out_valid", out_valid, m_ov);
    chk("sum", sum, m_sum);
    chk("out_last", out_last, m_last);
    chk("carry_out", carry_out, m_cout);
    chk("in_ready", in_ready, rdy);
    chk("busy", busy, m_idx != 0);
    acc = iv && rdy;
    @(posedge clk);
    if (acc) begin
      m_ov = 1'b1;
      m_sum = es;
      m_last = el;
      m_cout = ec;
      m_idx = (m_idx + 1) % 4;
    end else if (m_ov && ordy) begin
      m_ov = 1'b0;
      m_last = 1'b0;
      m_cout = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic run_op(input logic [31:0] opa, input logic [31:0] opb,
                        input int stall_after, input int stall_len,
                        input bit rnd);
    logic [32:0] full;
    logic acc, iv, ordy;
    int k, st, guard;
    full = {1'b0, opa} + {1'b0, opb};
    k = 0;
    st = stall_len;
    guard = 0;
    while (k < 4 && guard < 200) begin
      iv = 1'b1;
      ordy = 1'b1;
      if (rnd) begin
        iv = ($urandom_range(0, 3) != 0);
        ordy = ($urandom_range(0, 3) != 0);
      end
      if (k == stall_after + 1 && st > 0) begin
        ordy = 1'b0;
        st--;
      end
      cycle(iv, opa[8*k +: 8], opb[8*k +: 8], ordy,
            full[8*k +: 8], k == 3, (k == 3) ? full[32] : 1'b0, acc);
      if (acc) k++;
      guard++;
    end
    if (guard >= 200) chk("op_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain_out();
    logic acc;
    int guard;
    guard = 0;
    while (m_ov && guard < 20) begin
      cycle(1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, acc);
      guard++;
    end
    cycle(1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, acc);
  endtask

  initial begin
    logic acc;
    logic [32:0] full;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", sum, 8'h00);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_carry_out", carry_out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_n1_out_valid", n1_out_valid, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(32'h0000_00FF, 32'h0000_0001, -1, 0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, -1, 0, 1'b0);
    run_op(32'h0000_0001, 32'h0000_0001, -1, 0, 1'b0);
    drain_out();

    run_op(32'h1234_5678, 32'h1111_1111, 2, 3, 1'b0);
    drain_out();

    full = {1'b0, 32'hFFFF_FFFF} + 33'd1;
    cycle(1'b1, 8'hFF, 8'h01, 1'b1, full[7:0], 1'b0, 1'b0, acc);
    cycle(1'b1, 8'hFF, 8'h00, 1'b1, full[15:8], 1'b0, 1'b0, acc);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_sum", sum, 8'h00);
    m_ov = 1'b0;
    m_sum = 8'h00;
    m_last = 1'b0;
    m_cout = 1'b0;
    m_idx = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(32'h0000_0003, 32'h0000_0004, -1, 0, 1'b0);
    drain_out();

    cycle(1'b1, 8'hAA, 8'h11, 1'b0, 8'hBB, 1'b0, 1'b0, acc);
    in_valid = 1'b1;
    out_ready = 1'b0;
    clr = 1'b1;
    #1;
    chk("clr_in_ready", in_ready, 1'b0);
    chk("clr_pending", out_valid, 1'b1);
    @(posedge clk);
    m_ov = 1'b0;
    m_last = 1'b0;
    m_cout = 1'b0;
    m_idx = 0;
    @(negedge clk);
    clr = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("clr_out_valid", out_valid, 1'b0);
    chk("clr_busy", busy, 1'b0);
    run_op(32'h0000_0005, 32'h0000_0005, -1, 0, 1'b0);
    drain_out();

    for (int i = 0; i < 20; i++) begin
      run_op($urandom, $urandom, -1, 0, 1'b1);
    end
    drain_out();

    n1_a = 8'h80;
    n1_b = 8'h80;
    n1_in_valid = 1'b1;
    n1_out_ready = 1'b1;
    #1;
    chk("n1_in_ready", n1_in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    n1_in_valid = 1'b0;
    #1;
    chk("n1_out_valid", n1_out_valid, 1'b1);
    chk("n1_sum", n1_sum, 8'h00);
    chk("n1_out_last", n1_out_last, 1'b1);
    chk("n1_carry_out", n1_carry_out, 1'b1);
    n1_a = 8'h12;
    n1_b = 8'h34;
    n1_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n1_in_valid = 1'b0;
    #1;
    chk("n1_sum2", n1_sum, 8'h46);
    chk("n1_carry_out2", n1_carry_out, 1'b0);
    chk("n1_out_last2", n1_out_last, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("n1_drained", n1_out_valid, 1'b0);
    chk("n1_never_busy", n1_seen_busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
